// File: rtl/ooo_pkg.sv
// ooo_pkg: types shared by the out-of-order core datapath blocks.
package ooo_pkg;
    localparam int REG_SIZE  = 64;
    localparam int GPR_COUNT = 32;
    localparam int TAG_W_MAX = 8;   // widest ROB tag any instance may carry

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7
    } op_e;

    // Operand slot: value present when valid, otherwise tag names the producer.
    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [REG_SIZE-1:0]  value;
    } rs_op;

    typedef struct packed {
        logic [3:0]           opcode;
        logic [TAG_W_MAX-1:0] dst_tag;
        logic [REG_SIZE-1:0]  val1;
        logic [REG_SIZE-1:0]  val2;
    } issue_pkt_t;
endpackage

// File: rtl/reservation_station_if.sv
// reservation_station_if: dispatch, CDB broadcast and issue handshake signals.
interface reservation_station_if #(
    parameter int TAG_W    = 1,
    parameter int REG_SIZE = 64,
    parameter int OP_W     = 4
);
    import ooo_pkg::*;

    logic                i_disp_valid;
    logic                o_disp_ready;
    logic [OP_W-1:0]     i_disp_opcode;
    logic [TAG_W-1:0]    i_disp_dst_tag;
    rs_op                i_disp_op1;
    rs_op                i_disp_op2;
    logic                i_cdb_valid;
    logic [TAG_W-1:0]    i_cdb_tag;
    logic [REG_SIZE-1:0] i_cdb_value;
    logic                o_issue_valid;
    logic                i_issue_ready;
    logic [OP_W-1:0]     o_issue_opcode;
    logic [TAG_W-1:0]    o_issue_dst_tag;
    logic [REG_SIZE-1:0] o_issue_val1;
    logic [REG_SIZE-1:0] o_issue_val2;

    modport master (
        output i_disp_valid, i_disp_opcode, i_disp_dst_tag, i_disp_op1, i_disp_op2,
               i_cdb_valid, i_cdb_tag, i_cdb_value, i_issue_ready,
        input  o_disp_ready, o_issue_valid, o_issue_opcode, o_issue_dst_tag,
               o_issue_val1, o_issue_val2
    );

    modport slave (
        input  i_disp_valid, i_disp_opcode, i_disp_dst_tag, i_disp_op1, i_disp_op2,
               i_cdb_valid, i_cdb_tag, i_cdb_value, i_issue_ready,
        output o_disp_ready, o_issue_valid, o_issue_opcode, o_issue_dst_tag,
               o_issue_val1, o_issue_val2
    );
endinterface

// File: rtl/rs_age_select.sv
// rs_age_select: picks the oldest ready entry using a pairwise age matrix.
module rs_age_select #(
    parameter int N = 2
) (
    input  logic [N-1:0]        ready_i,
    input  logic [N-1:0][N-1:0] age_i,    // age_i[j][i] = 1: entry j older than i
    output logic [N-1:0]        grant_o,
    output logic                any_o
);
    // An entry wins when no other ready entry is older than it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant_o[i] = ready_i[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && ready_i[j] && age_i[j][i]) grant_o[i] = 1'b0;
            end
        end
    end

    assign any_o = |grant_o;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds dispatched ops until both operands are present,
// captures results from the CDB, and issues oldest-first through a registered port.
module reservation_station #(
    parameter int RS_SIZE  = 2,
    parameter int ROB_SIZE = 2,
    parameter int REG_SIZE = 64,
    parameter int OP_W     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_flush,
    reservation_station_if.slave         bus,
    output logic [$clog2(RS_SIZE+1)-1:0] o_count
);
    import ooo_pkg::*;

    localparam int TAG_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int CNT_W = $clog2(RS_SIZE + 1);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [REG_SIZE-1:0] value;
    } opnd_t;

    // Capture the broadcast value when the operand is still waiting on that tag.
    function automatic opnd_t wake(opnd_t o, logic cdb_v, logic [TAG_W-1:0] cdb_t,
                                   logic [REG_SIZE-1:0] cdb_val);
        opnd_t r = o;
        if (!o.valid && cdb_v && (o.tag == cdb_t)) begin
            r.valid = 1'b1;
            r.value = cdb_val;
        end
        return r;
    endfunction

    logic [RS_SIZE-1:0]              busy_q, busy_d;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [OP_W-1:0]                 opc_q [RS_SIZE];
    logic [TAG_W-1:0]                dst_q [RS_SIZE];
    opnd_t                           op1_q [RS_SIZE], op1_d [RS_SIZE];
    opnd_t                           op2_q [RS_SIZE], op2_d [RS_SIZE];
    logic                            iss_vld_q, iss_vld_d;
    logic [OP_W-1:0]                 iss_opc_q, iss_opc_d;
    logic [TAG_W-1:0]                iss_dst_q, iss_dst_d;
    logic [REG_SIZE-1:0]             iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d;

    logic [RS_SIZE-1:0] alloc, rdy, grant;
    logic               disp_ready, disp_fire, grant_any, iss_load;
    opnd_t              raw_op1, raw_op2, in_op1, in_op2;

    // Only the low TAG_W bits of an incoming tag are meaningful.
    if (TAG_W < TAG_W_MAX) begin : g_tag_hi
        logic unused_tag_hi;
        assign unused_tag_hi = ^{bus.i_disp_op1.tag[TAG_W_MAX-1:TAG_W],
                                 bus.i_disp_op2.tag[TAG_W_MAX-1:TAG_W]};
    end

    // Narrow the dispatched operands to this instance's tag width.
    always_comb begin
        raw_op1.valid = bus.i_disp_op1.valid;
        raw_op1.tag   = bus.i_disp_op1.tag[TAG_W-1:0];
        raw_op1.value = bus.i_disp_op1.value;
        raw_op2.valid = bus.i_disp_op2.valid;
        raw_op2.tag   = bus.i_disp_op2.tag[TAG_W-1:0];
        raw_op2.value = bus.i_disp_op2.value;
    end

    assign in_op1 = wake(raw_op1, bus.i_cdb_valid, bus.i_cdb_tag, bus.i_cdb_value);
    assign in_op2 = wake(raw_op2, bus.i_cdb_valid, bus.i_cdb_tag, bus.i_cdb_value);

    // Lowest-index free entry takes the next dispatch; candidates need both operands.
    always_comb begin
        alloc = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
        end
        for (int i = 0; i < RS_SIZE; i++) rdy[i] = busy_q[i] & op1_q[i].valid & op2_q[i].valid;
    end

    assign disp_ready = |(~busy_q);
    assign disp_fire  = bus.i_disp_valid & disp_ready & ~i_flush;
    assign iss_load   = grant_any & (~iss_vld_q | bus.i_issue_ready);

    rs_age_select #(.N(RS_SIZE)) u_sel (
        .ready_i (rdy),
        .age_i   (age_q),
        .grant_o (grant),
        .any_o   (grant_any)
    );

    // Operand next-state: dispatch write with CDB bypass, otherwise wake in place.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            op1_d[i] = wake(op1_q[i], bus.i_cdb_valid, bus.i_cdb_tag, bus.i_cdb_value);
            op2_d[i] = wake(op2_q[i], bus.i_cdb_valid, bus.i_cdb_tag, bus.i_cdb_value);
            if (disp_fire && alloc[i]) begin
                op1_d[i] = in_op1;
                op2_d[i] = in_op2;
            end
        end
    end

    // Busy, age and occupancy next-state; flush overrides everything.
    always_comb begin
        busy_d  = busy_q;
        age_d   = age_q;
        count_d = count_q;
        if (i_flush) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            if (iss_load) busy_d = busy_d & ~grant;
            if (disp_fire) begin
                busy_d = busy_d | alloc;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (alloc[i]) age_d[i] = '0;
                    for (int j = 0; j < RS_SIZE; j++) begin
                        if (alloc[j]) age_d[i][j] = busy_q[i];
                    end
                end
            end
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_load);
        end
    end

    // Issue register: load the winner, drain on ready, hold while stalled.
    always_comb begin
        iss_vld_d = iss_vld_q;
        iss_opc_d = iss_opc_q;
        iss_dst_d = iss_dst_q;
        iss_v1_d  = iss_v1_q;
        iss_v2_d  = iss_v2_q;
        if (i_flush) begin
            iss_vld_d = 1'b0;
        end else if (iss_load) begin
            iss_vld_d = 1'b1;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (grant[i]) begin
                    iss_opc_d = opc_q[i];
                    iss_dst_d = dst_q[i];
                    iss_v1_d  = op1_q[i].value;
                    iss_v2_d  = op2_q[i].value;
                end
            end
        end else if (bus.i_issue_ready) begin
            iss_vld_d = 1'b0;
        end
    end

    // Entry payload: busy gates its use, so it carries no reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            op1_q[i] <= op1_d[i];
            op2_q[i] <= op2_d[i];
            if (disp_fire && alloc[i]) begin
                opc_q[i] <= bus.i_disp_opcode;
                dst_q[i] <= bus.i_disp_dst_tag;
            end
        end
    end

    // Control state and issue register, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q    <= '0;
            age_q     <= '0;
            count_q   <= '0;
            iss_vld_q <= 1'b0;
            iss_opc_q <= '0;
            iss_dst_q <= '0;
            iss_v1_q  <= '0;
            iss_v2_q  <= '0;
        end else begin
            busy_q    <= busy_d;
            age_q     <= age_d;
            count_q   <= count_d;
            iss_vld_q <= iss_vld_d;
            iss_opc_q <= iss_opc_d;
            iss_dst_q <= iss_dst_d;
            iss_v1_q  <= iss_v1_d;
            iss_v2_q  <= iss_v2_d;
        end
    end

    assign bus.o_disp_ready    = disp_ready;
    assign bus.o_issue_valid   = iss_vld_q;
    assign bus.o_issue_opcode  = iss_opc_q;
    assign bus.o_issue_dst_tag = iss_dst_q;
    assign bus.o_issue_val1    = iss_v1_q;
    assign bus.o_issue_val2    = iss_v2_q;
    assign o_count             = count_q;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios for the reservation station
// (RS_SIZE=4, ROB_SIZE=8, REG_SIZE=64).
module tb_reservation_station;
    import ooo_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    reservation_station_if #(.TAG_W(3), .REG_SIZE(64), .OP_W(4)) bus ();

    reservation_station #(
        .RS_SIZE (4),
        .ROB_SIZE(8),
        .REG_SIZE(64),
        .OP_W    (4)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_flush  (flush),
        .bus      (bus),
        .o_count  (count)
    );

    function automatic rs_op mk(input logic v, input logic [7:0] t, input logic [63:0] val);
        rs_op o;
        o.valid = v;
        o.tag   = t;
        o.value = val;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_disp_valid   = 1'b0;
        bus.i_disp_opcode  = '0;
        bus.i_disp_dst_tag = '0;
        bus.i_disp_op1     = '0;
        bus.i_disp_op2     = '0;
        bus.i_cdb_valid    = 1'b0;
        bus.i_cdb_tag      = '0;
        bus.i_cdb_value    = '0;
    endtask

    task automatic disp(input logic [3:0] opc, input logic [2:0] dst, input rs_op a, input rs_op b);
        bus.i_disp_valid   = 1'b1;
        bus.i_disp_opcode  = opc;
        bus.i_disp_dst_tag = dst;
        bus.i_disp_op1     = a;
        bus.i_disp_op2     = b;
    endtask

    task automatic cdb(input logic [2:0] t, input logic [63:0] v);
        bus.i_cdb_valid = 1'b1;
        bus.i_cdb_tag   = t;
        bus.i_cdb_value = v;
    endtask

    task automatic test_reset();
        idle();
        bus.i_issue_ready = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", bus.o_issue_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (bus.o_disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b want 1", bus.o_disp_ready); end
        checks++; if (bus.o_issue_val1 !== 64'd0 || bus.o_issue_val2 !== 64'd0) begin errors++; $display("FAIL reset_issue_vals: got %h/%h want 0/0", bus.o_issue_val1, bus.o_issue_val2); end
        checks++; if (bus.o_issue_opcode !== 4'd0 || bus.o_issue_dst_tag !== 3'd0) begin errors++; $display("FAIL reset_issue_opc_dst: got %h/%h want 0/0", bus.o_issue_opcode, bus.o_issue_dst_tag); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.o_disp_ready !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL reset_release: ready %b count %0d want 1/0", bus.o_disp_ready, count); end
    endtask

    task automatic test_basic();
        bus.i_issue_ready = 1'b1;
        idle(); disp(4'(OP_ADD), 3'd3, mk(1'b1, 8'd0, 64'd5), mk(1'b1, 8'd0, 64'd7));
        tick(); // cycle 1
        idle();
        checks++; if (count !== 3'd1 || bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL basic_c1: count %0d valid %b want 1/0", count, bus.o_issue_valid); end
        tick(); // cycle 2
        checks++; if (bus.o_issue_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.o_issue_valid); end
        checks++; if (bus.o_issue_val1 !== 64'd5 || bus.o_issue_val2 !== 64'd7) begin errors++; $display("FAIL basic_vals: got %0d/%0d want 5/7", bus.o_issue_val1, bus.o_issue_val2); end
        checks++; if (bus.o_issue_dst_tag !== 3'd3 || bus.o_issue_opcode !== 4'(OP_ADD)) begin errors++; $display("FAIL basic_dst_opc: got %0d/%0d want 3/1", bus.o_issue_dst_tag, bus.o_issue_opcode); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_count: got %0d want 0", count); end
        tick(); // cycle 3
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", bus.o_issue_valid); end
    endtask

    task automatic test_wakeup();
        bus.i_issue_ready = 1'b1;
        idle(); disp(4'(OP_SUB), 3'd4, mk(1'b1, 8'd0, 64'd1), mk(1'b0, 8'd6, 64'd0));
        tick(); // c1
        idle(); cdb(3'd5, 64'h55);
        checks++; if (count !== 3'd1 || bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL wake_c1: count %0d valid %b want 1/0", count, bus.o_issue_valid); end
        tick(); // c2
        idle();
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL wake_c2: got %b want 0", bus.o_issue_valid); end
        tick(); // c3
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wrong_tag: got %b want 0", bus.o_issue_valid); end
        tick(); // c4
        cdb(3'd6, 64'hDEAD);
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL wake_c4: got %b want 0", bus.o_issue_valid); end
        tick(); // c5
        idle();
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL wake_no_bypass_select: got %b want 0", bus.o_issue_valid); end
        tick(); // c6
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_val2 !== 64'hDEAD) begin errors++; $display("FAIL wake_issue: valid %b val2 %h want 1/dead", bus.o_issue_valid, bus.o_issue_val2); end
        checks++; if (bus.o_issue_val1 !== 64'd1 || bus.o_issue_dst_tag !== 3'd4 || count !== 3'd0) begin errors++; $display("FAIL wake_fields: val1 %0d dst %0d count %0d want 1/4/0", bus.o_issue_val1, bus.o_issue_dst_tag, count); end
        tick(); // c7
    endtask

    task automatic test_bypass();
        bus.i_issue_ready = 1'b1;
        idle(); disp(4'(OP_OR), 3'd2, mk(1'b0, 8'd2, 64'd0), mk(1'b1, 8'd0, 64'd3)); cdb(3'd2, 64'd9);
        tick(); // c1
        idle();
        tick(); // c2
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_val1 !== 64'd9 || bus.o_issue_val2 !== 64'd3) begin errors++; $display("FAIL bypass_issue: valid %b vals %0d/%0d want 1/9/3", bus.o_issue_valid, bus.o_issue_val1, bus.o_issue_val2); end
        tick(); // c3
        checks++; if (bus.o_issue_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL bypass_drain: valid %b count %0d want 0/0", bus.o_issue_valid, count); end
    endtask

    task automatic test_oldest_first();
        bus.i_issue_ready = 1'b1;
        // A woken before any selection: expect A, B, C
        idle(); disp(4'(OP_AND), 3'd1, mk(1'b0, 8'd1, 64'd0), mk(1'b1, 8'd0, 64'd10));
        tick(); // c1
        idle(); disp(4'(OP_AND), 3'd2, mk(1'b1, 8'd0, 64'd20), mk(1'b1, 8'd0, 64'd21)); cdb(3'd1, 64'h11);
        tick(); // c2
        idle(); disp(4'(OP_AND), 3'd3, mk(1'b1, 8'd0, 64'd30), mk(1'b1, 8'd0, 64'd31));
        checks++; if (bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL age1_c2: got %b want 0", bus.o_issue_valid); end
        tick(); // c3
        idle();
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'd1 || bus.o_issue_val1 !== 64'h11) begin errors++; $display("FAIL age1_first: valid %b dst %0d val1 %h want 1/1/11", bus.o_issue_valid, bus.o_issue_dst_tag, bus.o_issue_val1); end
        tick(); // c4
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'd2) begin errors++; $display("FAIL age1_second: valid %b dst %0d want 1/2", bus.o_issue_valid, bus.o_issue_dst_tag); end
        tick(); // c5
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'd3) begin errors++; $display("FAIL age1_third: valid %b dst %0d want 1/3", bus.o_issue_valid, bus.o_issue_dst_tag); end
        tick(); // c6
        checks++; if (bus.o_issue_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL age1_empty: valid %b count %0d want 0/0", bus.o_issue_valid, count); end
        // A woken after B is selected: expect B, C, A
        idle(); disp(4'(OP_AND), 3'd4, mk(1'b0, 8'd5, 64'd0), mk(1'b1, 8'd0, 64'd40));
        tick(); // c1
        idle(); disp(4'(OP_AND), 3'd5, mk(1'b1, 8'd0, 64'd50), mk(1'b1, 8'd0, 64'd51));
        tick(); // c2
        idle(); disp(4'(OP_AND), 3'd6, mk(1'b1, 8'd0, 64'd60), mk(1'b1, 8'd0, 64'd61));
        tick(); // c3
        idle(); cdb(3'd5, 64'h77);
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'd5) begin errors++; $display("FAIL age2_first: valid %b dst %0d want 1/5", bus.o_issue_valid, bus.o_issue_dst_tag); end
        tick(); // c4
        idle();
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'd6) begin errors++; $display("FAIL age2_second: valid %b dst %0d want 1/6", bus.o_issue_valid, bus.o_issue_dst_tag); end
        tick(); // c5
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'd4 || bus.o_issue_val1 !== 64'h77) begin errors++; $display("FAIL age2_third: valid %b dst %0d val1 %h want 1/4/77", bus.o_issue_valid, bus.o_issue_dst_tag, bus.o_issue_val1); end
        tick(); // c6
        checks++; if (bus.o_issue_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL age2_empty: valid %b count %0d want 0/0", bus.o_issue_valid, count); end
    endtask

    task automatic test_full_backpressure();
        bus.i_issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(); disp(4'(OP_XOR), 3'(k), mk(1'b1, 8'd0, 64'(100 + k)), mk(1'b1, 8'd0, 64'(200 + k)));
            tick();
        end
        // c4: D0 in the issue register, D1..D3 held
        checks++; if (count !== 3'd3 || bus.o_disp_ready !== 1'b1) begin errors++; $display("FAIL full_c4: count %0d ready %b want 3/1", count, bus.o_disp_ready); end
        checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_val1 !== 64'd100) begin errors++; $display("FAIL full_hold_c4: valid %b val1 %0d want 1/100", bus.o_issue_valid, bus.o_issue_val1); end
        idle(); disp(4'(OP_XOR), 3'd4, mk(1'b1, 8'd0, 64'd104), mk(1'b1, 8'd0, 64'd204));
        tick(); // c5
        checks++; if (count !== 3'd4 || bus.o_disp_ready !== 1'b0) begin errors++; $display("FAIL full_c5: count %0d ready %b want 4/0", count, bus.o_disp_ready); end
        idle(); disp(4'(OP_XOR), 3'd5, mk(1'b1, 8'd0, 64'd105), mk(1'b1, 8'd0, 64'd205));
        tick(); // c6
        idle();
        checks++; if (count !== 3'd4 || bus.o_issue_val1 !== 64'd100 || bus.o_issue_dst_tag !== 3'd0) begin errors++; $display("FAIL full_stall_c6: count %0d val1 %0d dst %0d want 4/100/0", count, bus.o_issue_val1, bus.o_issue_dst_tag); end
        bus.i_issue_ready = 1'b1;
        checks++; if (bus.o_disp_ready !== 1'b0) begin errors++; $display("FAIL full_move_ready: got %b want 0", bus.o_disp_ready); end
        tick(); // c7
        checks++; if (bus.o_issue_dst_tag !== 3'd1 || bus.o_issue_val1 !== 64'd101 || count !== 3'd3 || bus.o_disp_ready !== 1'b1) begin errors++; $display("FAIL full_drain1: dst %0d val1 %0d count %0d ready %b want 1/101/3/1", bus.o_issue_dst_tag, bus.o_issue_val1, count, bus.o_disp_ready); end
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_dst_tag !== 3'(k) || bus.o_issue_val2 !== 64'(200 + k)) begin errors++; $display("FAIL full_drain%0d: valid %b dst %0d val2 %0d want 1/%0d/%0d", k, bus.o_issue_valid, bus.o_issue_dst_tag, bus.o_issue_val2, k, 200 + k); end
        end
        tick(); // c11
        checks++; if (bus.o_issue_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL full_empty: valid %b count %0d want 0/0", bus.o_issue_valid, count); end
    endtask

    task automatic test_flush();
        bus.i_issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(); disp(4'(OP_SLL), 3'(k), mk(1'b1, 8'd0, 64'(k)), mk(1'b1, 8'd0, 64'd1));
            tick();
        end
        checks++; if (count !== 3'd3 || bus.o_issue_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: count %0d valid %b want 3/1", count, bus.o_issue_valid); end
        idle(); disp(4'(OP_ADD), 3'd7, mk(1'b1, 8'd0, 64'd8), mk(1'b1, 8'd0, 64'd9));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        checks++; if (count !== 3'd0 || bus.o_issue_valid !== 1'b0 || bus.o_disp_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: count %0d valid %b ready %b want 0/0/1", count, bus.o_issue_valid, bus.o_disp_ready); end
        bus.i_issue_ready = 1'b1;
        tick();
        tick();
        checks++; if (count !== 3'd0 || bus.o_issue_valid !== 1'b0) begin errors++; $display("FAIL flush_nothing_left: count %0d valid %b want 0/0", count, bus.o_issue_valid); end
    endtask

    task automatic test_reset_mid_stall();
        bus.i_issue_ready = 1'b0;
        idle(); disp(4'(OP_SUB), 3'd1, mk(1'b1, 8'd0, 64'hA), mk(1'b1, 8'd0, 64'hB));
        tick();
        idle(); disp(4'(OP_SUB), 3'd2, mk(1'b1, 8'd0, 64'hC), mk(1'b1, 8'd0, 64'hD));
        tick();
        idle();
        tick();
        checks++; if (bus.o_issue_valid !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL rst_pre: valid %b count %0d want 1/1", bus.o_issue_valid, count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.o_issue_valid !== 1'b0 || count !== 3'd0 || bus.o_disp_ready !== 1'b1) begin errors++; $display("FAIL rst_async: valid %b count %0d ready %b want 0/0/1", bus.o_issue_valid, count, bus.o_disp_ready); end
        checks++; if (bus.o_issue_val1 !== 64'd0 || bus.o_issue_dst_tag !== 3'd0 || bus.o_issue_opcode !== 4'd0) begin errors++; $display("FAIL rst_async_data: val1 %h dst %0d opc %0d want 0/0/0", bus.o_issue_val1, bus.o_issue_dst_tag, bus.o_issue_opcode); end
        #1 rst_n = 1'b1;
        bus.i_issue_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.o_issue_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rst_after: valid %b count %0d want 0/0", bus.o_issue_valid, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_oldest_first();
        test_full_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
# reservation_station

- Holds dispatched ops until both operands are valid, then issues them oldest-first to one execution unit.
- Sits between dispatch and the ALU inside `core`.
- Captures operand values from the common data bus (CDB) by tag match.
- Feeds a registered issue port with a valid/ready handshake.

## Interface
- `RS_SIZE`, 2, number of entries (≥2)
- `ROB_SIZE`, 2, ROB depth; tag width `TAG_W = $clog2(ROB_SIZE)` (min 1)
- `REG_SIZE`, 64, operand/result width
- `OP_W`, 4, opcode width
- `i_clk`  in  1  clock
- `i_reset_n`  in  1  reset; **single clock, asynchronous, active-low**
- `i_flush`  in  1  synchronous squash of all contents
- `i_disp_valid` / `o_disp_ready`  in/out  1  dispatch handshake
- `i_disp_opcode`  in  OP_W
- `i_disp_dst_tag`  in  TAG_W  ROB tag of result
- `i_disp_op1`, `i_disp_op2`  in  rs_op
  - `valid` = value present
  - otherwise `tag` names the producer
- `i_cdb_valid`, `i_cdb_tag`, `i_cdb_value`  in  1/TAG_W/REG_SIZE  result broadcast
- `o_issue_valid` / `i_issue_ready`  out/in  1  issue handshake
- `o_issue_opcode`, `o_issue_dst_tag`, `o_issue_val1`, `o_issue_val2`  out  issued op
- `o_count`  out  `$clog2(RS_SIZE+1)`  occupied entries

## Operation
**Entry state:** busy, opcode, dst_tag, op1, op2 (rs_op each), plus an age matrix. `age[i][j]=1` means entry i is older than j.

**Dispatch**
- `o_disp_ready` is combinational: 1 iff any entry is not busy (registered state only).
- On handshake, the op is written to the lowest-index free entry and marked younger than all busy entries.
- **Same-cycle bypass:** if an incoming operand is not valid and `i_cdb_valid` is high with a matching tag, the entry stores the CDB value with valid=1.

**Wakeup**
- Every busy entry with an invalid operand whose tag equals `i_cdb_tag` (while `i_cdb_valid`) captures the value and sets valid.
- Both operands of one entry may wake in the same cycle.

**Select**
- Candidates: busy entries with both operands valid, in registered state.
- Winner: the candidate that no other candidate is older than.
- The winner moves to the issue register when that register is empty or draining this cycle (`o_issue_valid & i_issue_ready`).
- The winner's entry is freed at that same edge.
- At most one issue per cycle.

**Issue register**
- Holds its contents stable while `o_issue_valid & !i_issue_ready`.
- Loading it is the only path out of the station.

**Flush**
- Takes priority over everything.
- At the next edge, clears all busy bits and `o_issue_valid`.
- Dispatch is ignored in a flush cycle (no entry written, although ready may read 1).

**Reset**
- Clears busy, age matrix, `o_issue_valid`.
- All issue data outputs read 0 and `o_count` = 0.
- `o_disp_ready` = 1 (station empty).

## Timing
- Dispatch with both operands valid, accepted in cycle c:
  - entry busy in c+1
  - selected in c+1
  - `o_issue_valid` in c+2
- CDB wakeup in cycle c: operand valid in c+1, earliest issue c+2. There is no CDB-to-select bypass in the same cycle.
- Freed entry: visible to `o_disp_ready` the cycle after the move.
- Full station with a simultaneous issue move: ready stays 0 that cycle.
- `o_count` is registered:
  - +1 for dispatch, −1 for move to the issue register
  - both in one cycle → unchanged
  - flush → 0
- Tag comparisons use the full TAG_W bits only. A value field is meaningless when its valid bit is 0.
- Backpressure: with the issue register full and stalled, ready entries stay in place and keep waking, but none move.

## Structure
- Shared package `ooo_pkg`:
  - `REG_SIZE`, `GPR_COUNT`
  - the `rs_op` struct (`valid`, `tag`, `value`)
  - opcode enum
  - issue-packet struct
- Sub-module `rs_age_select`: combinational, takes the ready vector and age matrix, outputs a one-hot grant plus an any-grant flag.
- Entry storage, wakeup, allocation and the issue register stay in `reservation_station`.

## Test plan
Configuration: RS_SIZE=4, ROB_SIZE=8, REG_SIZE=64.
1. **Basic issue:** dispatch ADD dst=3, op1={1,_,5}, op2={1,_,7} at cycle 0 → `o_issue_valid`=1 at cycle 2 with val1=5, val2=7, dst_tag=3; `o_count` returns to 0.
2. **Wakeup:**
   - dispatch op2={0,tag=6}; issue stays 0
   - CDB tag=6 value=0xDEAD at cycle 4 → issue at cycle 6 with val2=0xDEAD
   - CDB tag=5 causes no wake
3. **Dispatch bypass:** dispatch op1={0,tag=2} while CDB tag=2 value=9 is valid in the same cycle → entry issues 2 cycles later with val1=9.
4. **Oldest-first:**
   - dispatch A (waiting on tag 1), then ready B, then ready C
   - wake A
   - issue order B, C, A only if A wakes after B is selected; if A is woken before any selection, order is A, B, C
5. **Full/backpressure:**
   - 4 ready dispatches with `i_issue_ready`=0 → one in the issue register, 3 held; 5th dispatch sees ready=1, 6th sees ready=0
   - issue register holds stable
   - raising ready drains one per cycle in age order
6. **Flush/reset:**
   - `i_flush` with 3 busy entries plus a concurrent dispatch → next cycle `o_count`=0, `o_issue_valid`=0
   - `i_reset_n` low mid-stall clears outputs immediately, without a clock edge
